// File: rtl/wb_cmd_master.sv
// Single-outstanding pipelined Wishbone initiator. Turns a valid/ready command
// stream into Wishbone cycles and returns read data plus completion status.
module wb_cmd_master #(
  parameter int g_addr_width = 16,
  parameter int g_timeout    = 255,
  parameter int g_max_retry  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [g_addr_width-3:0] cmd_adr_i,
  input  logic [31:0]             cmd_dat_i,
  input  logic [3:0]              cmd_sel_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_dat_o,
  output logic [1:0]              rsp_status_o,
  output logic                    busy_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [g_addr_width-3:0] wb_adr_o,
  output logic [3:0]              wb_sel_o,
  output logic [31:0]             wb_dat_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  input  logic                    wb_stall_i,
  input  logic [31:0]             wb_dat_i
);

  localparam int c_tw = $clog2(g_timeout + 1);
  localparam int c_rw = (g_max_retry < 1) ? 1 : $clog2(g_max_retry + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STB,
    S_WAIT,
    S_RETRY,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERR     = 2'b01,
    ST_RTY_EXH = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_t;

  state_t          state_q, state_d;
  logic [c_tw-1:0] tmo_q;
  logic [c_rw-1:0] rty_cnt_q;
  logic [31:0]     rsp_dat_d;
  status_t         rsp_status_d;
  logic            accept;
  logic            bus_live;
  logic            tmo_hit;
  logic            rty_inc;

  // Next-state and response decode. A termination is only honoured once the
  // strobe has been taken (stall low) or while waiting, so a stalled strobe
  // cannot be completed early.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    state_d      = state_q;
    rsp_dat_d    = rsp_dat_o;
    rsp_status_d = status_t'(rsp_status_o);
    rty_inc      = 1'b0;
    accept       = cmd_valid_i & cmd_ready_o;
    bus_live     = (state_q == S_WAIT) || ((state_q == S_STB) && !wb_stall_i);
    tmo_hit      = (tmo_q == c_tw'(g_timeout - 1));

    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_STB;
      end
      S_STB, S_WAIT: begin
        if (bus_live && wb_err_i) begin
          state_d      = S_RESP;
          rsp_dat_d    = '0;
          rsp_status_d = ST_ERR;
        end else if (bus_live && wb_rty_i) begin
          if (rty_cnt_q < c_rw'(g_max_retry)) begin
            state_d = S_RETRY;
            rty_inc = 1'b1;
          end else begin
            state_d      = S_RESP;
            rsp_dat_d    = '0;
            rsp_status_d = ST_RTY_EXH;
          end
        end else if (bus_live && wb_ack_i) begin
          state_d      = S_RESP;
          rsp_dat_d    = wb_we_o ? 32'h0 : wb_dat_i;
          rsp_status_d = ST_OK;
        end else if (tmo_hit) begin
          state_d      = S_RESP;
          rsp_dat_d    = '0;
          rsp_status_d = ST_TIMEOUT;
        end else if ((state_q == S_STB) && !wb_stall_i) begin
          state_d = S_WAIT;
        end
      end
      S_RETRY: begin
        state_d = S_STB;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and every output are registered; outputs are decoded from
  // the next state so they line up with the state they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      rty_cnt_q    <= '0;
      cmd_ready_o  <= 1'b0;
      busy_o       <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      wb_dat_o     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q      <= state_d;
      cmd_ready_o  <= (state_d == S_IDLE);
      busy_o       <= (state_d != S_IDLE);
      rsp_valid_o  <= (state_d == S_RESP);
      wb_cyc_o     <= (state_d == S_STB) || (state_d == S_WAIT);
      wb_stb_o     <= (state_d == S_STB);
      rsp_dat_o    <= rsp_dat_d;
      rsp_status_o <= rsp_status_d;

      if (accept) begin
        wb_we_o   <= cmd_we_i;
        wb_adr_o  <= cmd_adr_i;
        wb_sel_o  <= cmd_sel_i;
        wb_dat_o  <= cmd_dat_i;
        rty_cnt_q <= '0;
      end else if (rty_inc) begin
        rty_cnt_q <= rty_cnt_q + 1'b1;
      end

      // Each attempt gets a fresh timeout window.
      if ((state_d == S_STB) && (state_q != S_STB)) begin
        tmo_q <= '0;
      end else if ((state_q == S_STB) || (state_q == S_WAIT)) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Single-outstanding pipelined Wishbone initiator, 32-bit data.
- Converts a valid/ready command stream (address, data, write-enable, byte-select) into Wishbone cycles and returns read data plus completion status on a valid/ready response stream.
- Drives CSR-style Wishbone slaves (register banks, submaps, RAM ports) from a local controller or sequencer.
- Handles stall, ack, err and rty, with bounded retries and an ack timeout.

Parameters:
- g_addr_width, 16, byte-address width; word address bits are [g_addr_width-1:2].
- g_timeout, 255, maximum cycles per attempt with cyc high before the transfer is aborted (>=2).
- g_max_retry, 3, number of re-issues allowed after rty (0 = none).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous assert, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  g_addr_width-2  word address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte selects
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_dat_o  out  32  read data (0 for writes or failed reads)
- rsp_status_o  out  2  00 ok, 01 err, 10 retry exhausted, 11 timeout
- busy_o  out  1  state != IDLE
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe, write
- wb_adr_o  out  g_addr_width-2  Wishbone address
- wb_sel_o  out  4  Wishbone byte selects
- wb_dat_o  out  32  Wishbone write data
- wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1 each  Wishbone slave responses
- wb_dat_i  in  32  Wishbone read data

Behaviour:
- Reset (asynchronous): all outputs 0 (cmd_ready_o=0), state IDLE, counters 0. cmd_ready_o rises in the first cycle after reset release.
- FSM states: IDLE, STB, WAIT, RETRY, RESP. All Wishbone outputs are registered.
- IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o, latch adr/dat/we/sel, clear the retry counter, go to STB. cyc and stb are high in the next cycle.
- STB: cyc=stb=1; adr/dat/we/sel held stable.
  - stall=1: remain in STB.
  - stall=0: stb drops next cycle and the state moves to WAIT.
  - If ack/err/rty is sampled in the same cycle as stall=0, it terminates the transfer directly (same rules as WAIT).
- WAIT: cyc=1, stb=0. Termination priority when inputs are simultaneous: err > rty > ack.
  - ack: capture wb_dat_i if read (0 for write), status 00, go to RESP.
  - err: data 0, status 01, go to RESP.
  - rty with retry count < g_max_retry: increment count, go to RETRY.
  - rty with retry count = g_max_retry: status 10, go to RESP.
- RETRY: cyc=stb=0 for exactly one cycle, then STB with the same latched command. The timeout counter restarts.
- Timeout counter: clears on entry to STB and counts every cycle in STB or WAIT. If it reaches g_timeout without a termination, abort with status 11 and go to RESP. A termination in that same cycle takes precedence over the timeout.
- RESP: cyc=stb=0, rsp_valid_o=1; rsp_dat_o and rsp_status_o are stable until rsp_valid_o&rsp_ready_i, then return to IDLE.
  - The next command is accepted no earlier than the cycle after the handshake.
  - ack/err/rty arriving while cyc=0 is ignored.
- cyc falls together with the terminating state change. No back-to-back cycles are issued; at most one transaction is outstanding.
- Latency, zero-wait slave that acks in the cycle after stb: accept@N, stb@N+1, ack@N+2, rsp_valid@N+3.
- Reset mid-transfer: cyc/stb drop immediately. Any pending response is discarded and no rsp_valid_o is produced.

Test Plan:
- Write adr=0x0003, dat=0xDEADBEEF, sel=0xF, slave no stall, ack 1 cycle after stb -> one cyc of 2 cycles (stb high 1 cycle), rsp_valid@N+3, status 00, rsp_dat=0.
- Read adr=0x0001, stall=1 for 3 cycles, ack with wb_dat_i=0x12345678 two cycles after stall release -> stb high exactly 4 cycles, adr stable throughout, rsp_dat=0x12345678, status 00.
- g_max_retry=3: rty twice then ack -> two RETRY gaps with cyc low for 1 cycle each, three stb pulses, status 00. Then rty four times -> four stb pulses, status 10. Simultaneous err+ack -> status 01.
- g_timeout=8, slave never responds -> cyc high exactly 8 cycles, then status 11. ack arriving afterward is ignored and does not produce a second response.
- Response backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o, rsp_dat_o and rsp_status_o held, cmd_ready_o=0. New cmd_valid_i is not accepted until the cycle after the handshake.
- Assert rst_i while in WAIT -> cyc/stb/rsp_valid_o go 0 without waiting for a clock edge. After release, cmd_ready_o=1 and a fresh read completes normally.
